// File: rtl/pc_gen_pkg.sv
// Shared encodings for the program-counter generator: next-PC opcodes,
// FSM state encoding and default reset/exception addresses.
package pc_gen_pkg;

  localparam logic [2:0] NPC_PC4 = 3'd0;
  localparam logic [2:0] NPC_BEQ = 3'd1;
  localparam logic [2:0] NPC_J   = 3'd2;
  localparam logic [2:0] NPC_JR  = 3'd3;

  typedef enum logic {
    S_RUN = 1'b0,
    S_EXC = 1'b1
  } pc_state_t;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

endpackage

// File: rtl/pc_gen_npc_calc.sv
// Combinational next-fetch-address generator: pc+4, conditional branch,
// J-type absolute jump and JR register jump. All arithmetic wraps modulo 2^AW.
import pc_gen_pkg::*;

module npc_calc #(
  parameter int AW = 32
) (
  input  logic [AW-1:0] pc,
  input  logic [2:0]    npc_op,
  input  logic          br_taken,
  input  logic [25:0]   imm,
  input  logic [AW-1:0] rd1,
  output logic [AW-1:0] pc_4,
  output logic [AW-1:0] npc
);

  logic [31:0]   br_off_full;
  logic [AW-1:0] br_target;
  logic [AW-1:0] j_target;
  logic [AW-1:0] jr_target;

  // Branch offset is a word offset, so sign-extend and scale by 4 before
  // narrowing to the address width.
  assign br_off_full = {{14{imm[15]}}, imm[15:0], 2'b00};
  assign pc_4        = pc + AW'(4);
  assign br_target   = pc_4 + br_off_full[AW-1:0];
  assign j_target    = {pc_4[AW-1:28], imm, 2'b00};
  assign jr_target   = {rd1[AW-1:2], 2'b00};

  // Select the redirect target; unused opcodes fall through to sequential fetch.
  always_comb begin
    npc = pc_4;
    case (npc_op)
      NPC_BEQ: npc = br_taken ? br_target : pc_4;
      NPC_J:   npc = j_target;
      NPC_JR:  npc = jr_target;
      default: npc = pc_4;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: owns the PC and EPC registers, the pending
// exception latch and the run/handler FSM; target arithmetic lives in npc_calc.
import pc_gen_pkg::*;

module pc_gen #(
  parameter int          AW       = 32,
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic [2:0]    npc_op,
  input  logic          br_taken,
  input  logic [25:0]   imm,
  input  logic [AW-1:0] rd1,
  input  logic          exc_req,
  input  logic          eret,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_4,
  output logic [AW-1:0] epc,
  output logic          in_exc
);

  pc_state_t     state;
  logic          pend;
  logic [AW-1:0] npc;
  logic          take_exc;
  logic          do_eret;

  npc_calc #(.AW(AW)) u_npc_calc (
    .pc       (pc),
    .npc_op   (npc_op),
    .br_taken (br_taken),
    .imm      (imm),
    .rd1      (rd1),
    .pc_4     (pc_4),
    .npc      (npc)
  );

  // An exception is only taken from normal execution and never mid-stall;
  // a request seen during a stall is remembered in pend instead.
  assign take_exc = (state == S_RUN) && (exc_req || pend) && !stall;
  assign do_eret  = (state == S_EXC) && eret;

  // PC/EPC/pend/FSM update in priority order: reset, exception, eret, stall, redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC[AW-1:0];
      epc    <= '0;
      pend   <= 1'b0;
      state  <= S_RUN;
      in_exc <= 1'b0;
    end else if (take_exc) begin
      pc     <= EXC_VEC[AW-1:0];
      epc    <= pc;
      pend   <= 1'b0;
      state  <= S_EXC;
      in_exc <= 1'b1;
    end else if (do_eret) begin
      pc     <= epc;
      state  <= S_RUN;
      in_exc <= 1'b0;
    end else if (stall) begin
      if (state == S_RUN && exc_req) begin
        pend <= 1'b1;
      end
    end else begin
      pc <= npc;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen: a 32-bit instance covers redirects, stall,
// exceptions and eret; a 30-bit instance covers address wrap-around.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [2:0]  npc_op;
  logic        br_taken;
  logic [25:0] imm;
  logic [31:0] rd1;
  logic        exc_req;
  logic        eret;

  logic [31:0] pc, pc_4, epc;
  logic        in_exc;
  logic [29:0] pc30, pc30_4, epc30;
  logic        in_exc30;

  int checks = 0;
  int errors = 0;

  pc_gen #(.AW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .npc_op   (npc_op),
    .br_taken (br_taken),
    .imm      (imm),
    .rd1      (rd1),
    .exc_req  (exc_req),
    .eret     (eret),
    .pc       (pc),
    .pc_4     (pc_4),
    .epc      (epc),
    .in_exc   (in_exc)
  );

  pc_gen #(.AW(30)) dut30 (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .npc_op   (npc_op),
    .br_taken (br_taken),
    .imm      (imm),
    .rd1      (rd1[29:0]),
    .exc_req  (exc_req),
    .eret     (eret),
    .pc       (pc30),
    .pc_4     (pc30_4),
    .epc      (epc30),
    .in_exc   (in_exc30)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, clock it in, then settle just past the edge.
  task automatic applyStimulus(input logic r, input logic st, input logic [2:0] op,
                               input logic bt, input logic [25:0] im, input logic [31:0] rd,
                               input logic ex, input logic er);
    rst      = r;
    stall    = st;
    npc_op   = op;
    br_taken = bt;
    imm      = im;
    rd1      = rd;
    exc_req  = ex;
    eret     = er;
    @(posedge clk);
    #1;
  endtask

  // Compare an observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Linear directed sequence.
  initial begin
    rst = 1'b1; stall = 1'b0; npc_op = 3'd0; br_taken = 1'b0;
    imm = '0; rd1 = '0; exc_req = 1'b0; eret = 1'b0;

    applyStimulus(1, 0, 3'd0, 0, 26'h0, 32'h0, 0, 0);
    checkOutput("reset_pc", pc, 32'h0000_3000);
    checkOutput("reset_epc", epc, 32'h0);
    checkOutput("reset_in_exc", {31'b0, in_exc}, 32'h0);
    checkOutput("reset_pc30", {2'b0, pc30}, 32'h0000_3000);

    applyStimulus(0, 0, 3'd0, 0, 26'h0, 32'h0, 0, 0);
    checkOutput("pc4_1", pc, 32'h0000_3004);
    applyStimulus(0, 0, 3'd0, 0, 26'h0, 32'h0, 0, 0);
    checkOutput("pc4_2", pc, 32'h0000_3008);
    applyStimulus(0, 0, 3'd0, 0, 26'h0, 32'h0, 0, 0);
    checkOutput("pc4_3", pc, 32'h0000_300C);
    checkOutput("pc_4_comb", pc_4, 32'h0000_3010);
    checkOutput("pc4_epc", epc, 32'h0);
    checkOutput("pc4_in_exc", {31'b0, in_exc}, 32'h0);

    applyStimulus(0, 0, 3'd0, 0, 26'h0, 32'h0, 0, 0);
    checkOutput("at_3010", pc, 32'h0000_3010);
    applyStimulus(0, 0, 3'd1, 1, 26'h000FFFC, 32'h0, 0, 0);
    checkOutput("beq_back", pc, 32'h0000_3004);
    applyStimulus(0, 0, 3'd3, 0, 26'h0, 32'h0000_3010, 0, 0);
    applyStimulus(0, 0, 3'd1, 0, 26'h000FFFC, 32'h0, 0, 0);
    checkOutput("beq_not_taken", pc, 32'h0000_3014);
    applyStimulus(0, 0, 3'd3, 0, 26'h0, 32'h0000_3010, 0, 0);
    applyStimulus(0, 0, 3'd1, 1, 26'h0000004, 32'h0, 0, 0);
    checkOutput("beq_fwd", pc, 32'h0000_3024);
    applyStimulus(0, 0, 3'd2, 1, 26'h0000004, 32'h0, 0, 0);
    checkOutput("j_ignores_br", pc, 32'h0000_0010);

    applyStimulus(0, 0, 3'd3, 0, 26'h0, 32'hA000_0100, 0, 0);
    checkOutput("jr_high", pc, 32'hA000_0100);
    applyStimulus(0, 0, 3'd2, 0, 26'h0000040, 32'h0, 0, 0);
    checkOutput("j_same", pc, 32'hA000_0100);
    applyStimulus(0, 0, 3'd2, 0, 26'h3FFFFFF, 32'h0, 0, 0);
    checkOutput("j_max", pc, 32'hAFFF_FFFC);
    applyStimulus(0, 0, 3'd3, 0, 26'h0, 32'h0000_5007, 0, 0);
    checkOutput("jr_misaligned", pc, 32'h0000_5004);
    applyStimulus(0, 0, 3'd5, 1, 26'h0000004, 32'h0, 0, 0);
    checkOutput("op5_as_pc4", pc, 32'h0000_5008);

    applyStimulus(0, 1, 3'd3, 0, 26'h0, 32'h0000_9000, 0, 0);
    checkOutput("stall_hold", pc, 32'h0000_5008);

    applyStimulus(0, 0, 3'd3, 0, 26'h0, 32'h0000_3020, 0, 0);
    checkOutput("at_3020", pc, 32'h0000_3020);
    applyStimulus(0, 1, 3'd0, 0, 26'h0, 32'h0, 1, 0);
    checkOutput("stall_exc_pc", pc, 32'h0000_3020);
    checkOutput("stall_exc_in_exc", {31'b0, in_exc}, 32'h0);
    applyStimulus(0, 1, 3'd0, 0, 26'h0, 32'h0, 0, 0);
    checkOutput("stall_pend_pc", pc, 32'h0000_3020);
    applyStimulus(0, 0, 3'd0, 0, 26'h0, 32'h0, 0, 0);
    checkOutput("take_pc", pc, 32'h0000_4180);
    checkOutput("take_epc", epc, 32'h0000_3020);
    checkOutput("take_in_exc", {31'b0, in_exc}, 32'h1);
    applyStimulus(0, 0, 3'd0, 0, 26'h0, 32'h0, 1, 0);
    checkOutput("handler_ignore_pc", pc, 32'h0000_4184);
    checkOutput("handler_ignore_epc", epc, 32'h0000_3020);
    applyStimulus(0, 0, 3'd0, 0, 26'h0, 32'h0, 0, 1);
    checkOutput("eret_pc", pc, 32'h0000_3020);
    checkOutput("eret_in_exc", {31'b0, in_exc}, 32'h0);
    checkOutput("eret_epc", epc, 32'h0000_3020);
    applyStimulus(0, 0, 3'd0, 0, 26'h0, 32'h0, 0, 0);
    checkOutput("after_eret_pc4", pc, 32'h0000_3024);

    applyStimulus(0, 0, 3'd0, 0, 26'h0, 32'h0, 0, 1);
    checkOutput("eret_in_run", pc, 32'h0000_3028);
    checkOutput("eret_in_run_in_exc", {31'b0, in_exc}, 32'h0);

    applyStimulus(0, 0, 3'd0, 0, 26'h0, 32'h0, 1, 0);
    checkOutput("take2_pc", pc, 32'h0000_4180);
    checkOutput("take2_epc", epc, 32'h0000_3028);
    applyStimulus(0, 1, 3'd0, 0, 26'h0, 32'h0, 1, 1);
    checkOutput("eret_stalled", pc, 32'h0000_3028);
    applyStimulus(0, 0, 3'd0, 0, 26'h0, 32'h0, 1, 0);
    checkOutput("retake_pc", pc, 32'h0000_4180);
    checkOutput("retake_in_exc", {31'b0, in_exc}, 32'h1);

    applyStimulus(1, 0, 3'd0, 0, 26'h0, 32'h0, 0, 0);
    checkOutput("rst_exc_pc", pc, 32'h0000_3000);
    checkOutput("rst_exc_in_exc", {31'b0, in_exc}, 32'h0);
    checkOutput("rst_exc_epc", epc, 32'h0);

    applyStimulus(0, 1, 3'd0, 0, 26'h0, 32'h0, 1, 0);
    applyStimulus(1, 0, 3'd0, 0, 26'h0, 32'h0, 0, 0);
    applyStimulus(0, 0, 3'd0, 0, 26'h0, 32'h0, 0, 0);
    checkOutput("rst_clears_pend", pc, 32'h0000_3004);
    checkOutput("rst_clears_pend_in_exc", {31'b0, in_exc}, 32'h0);

    applyStimulus(0, 0, 3'd3, 0, 26'h0, 32'h3FFF_FFFF, 0, 0);
    checkOutput("aw30_top", {2'b0, pc30}, 32'h3FFF_FFFC);
    checkOutput("aw30_pc_4_wrap", {2'b0, pc30_4}, 32'h0);
    applyStimulus(0, 0, 3'd0, 0, 26'h0, 32'h0, 0, 0);
    checkOutput("aw30_wrap", {2'b0, pc30}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
